// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment patterns
// (active-low, abcdefg order) and the digit-slot state encoding.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      D0 = 2'd0,
      D1 = 2'd1,
      D2 = 2'd2,
      D3 = 2'd3
   } digit_state_t;

   localparam logic [0:6] SEG_0     = 7'b000_0001;
   localparam logic [0:6] SEG_1     = 7'b100_1111;
   localparam logic [0:6] SEG_2     = 7'b001_0010;
   localparam logic [0:6] SEG_3     = 7'b000_0110;
   localparam logic [0:6] SEG_4     = 7'b100_1100;
   localparam logic [0:6] SEG_5     = 7'b010_0100;
   localparam logic [0:6] SEG_6     = 7'b010_0000;
   localparam logic [0:6] SEG_7     = 7'b000_1111;
   localparam logic [0:6] SEG_8     = 7'b000_0000;
   localparam logic [0:6] SEG_9     = 7'b000_0100;
   localparam logic [0:6] SEG_A     = 7'b000_1000;
   localparam logic [0:6] SEG_B     = 7'b110_0000;
   localparam logic [0:6] SEG_C     = 7'b011_0001;
   localparam logic [0:6] SEG_D     = 7'b100_0010;
   localparam logic [0:6] SEG_E     = 7'b011_0000;
   localparam logic [0:6] SEG_F     = 7'b011_1000;
   localparam logic [0:6] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [0:6] pattern
);

   // Table lookup of the glyph for one hex digit.
   always_comb begin
      pattern = SEG_BLANK;
      case (nibble)
         4'h0: pattern = SEG_0;
         4'h1: pattern = SEG_1;
         4'h2: pattern = SEG_2;
         4'h3: pattern = SEG_3;
         4'h4: pattern = SEG_4;
         4'h5: pattern = SEG_5;
         4'h6: pattern = SEG_6;
         4'h7: pattern = SEG_7;
         4'h8: pattern = SEG_8;
         4'h9: pattern = SEG_9;
         4'hA: pattern = SEG_A;
         4'hB: pattern = SEG_B;
         4'hC: pattern = SEG_C;
         4'hD: pattern = SEG_D;
         4'hE: pattern = SEG_E;
         4'hF: pattern = SEG_F;
         default: pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous
// display update, leading-zero blanking and PWM brightness.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic        load,
   input  logic        blank_lz,
   input  logic [2:0]  bright,
   output logic [3:0]  an,
   output logic [0:6]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int unsigned     CW         = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]   LAST_COUNT = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   digit_state_t  state, state_next;
   logic          wrap, frame_end;
   logic [15:0]   pend_val, disp_val;
   logic [3:0]    pend_dp, disp_dp, pend_en, disp_en;
   logic [1:0]    idx;
   logic [3:0]    nibble;
   logic [0:6]    pattern;
   logic [39:0]   on_len;
   logic          blanked, lit;

   seg_hex_decoder u_dec (
      .nibble  (nibble),
      .pattern (pattern)
   );

   // Slot counter: REFRESH_DIV cycles per digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt <= '0;
      else if (cnt == LAST_COUNT)  cnt <= '0;
      else                         cnt <= cnt + 1'b1;
   end

   // Digit state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= D0;
      else        state <= state_next;
   end

   // Next digit at slot wrap; frame ends on the last cycle of digit 3.
   always_comb begin
      wrap       = (cnt == LAST_COUNT);
      frame_end  = wrap && (state == D3);
      state_next = state;
      if (wrap) begin
         case (state)
            D0:      state_next = D1;
            D1:      state_next = D2;
            D2:      state_next = D3;
            D3:      state_next = D0;
            default: state_next = D0;
         endcase
      end
   end

   // Pending register: the last load within a frame wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val <= '0;
         pend_dp  <= '0;
         pend_en  <= '1;
      end else if (load) begin
         pend_val <= value;
         pend_dp  <= dp_in;
         pend_en  <= digit_en;
      end
   end

   // Display register: updated only at frame end so a frame never tears;
   // a load on that same cycle bypasses the pending register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_val <= '0;
         disp_dp  <= '0;
         disp_en  <= '1;
      end else if (frame_end) begin
         disp_val <= load ? value    : pend_val;
         disp_dp  <= load ? dp_in    : pend_dp;
         disp_en  <= load ? digit_en : pend_en;
      end
   end

   // Current digit selection, blanking and PWM on-window.
   always_comb begin
      idx    = state;
      nibble = disp_val[{idx, 2'b00} +: 4];
      on_len = ((40'(bright) + 40'd1) * 40'(REFRESH_DIV)) >> 3;
      case (idx)
         2'd3:    blanked = blank_lz && (disp_val[15:12] == 4'h0);
         2'd2:    blanked = blank_lz && (disp_val[15:8]  == 8'h00);
         2'd1:    blanked = blank_lz && (disp_val[15:4]  == 12'h000);
         default: blanked = 1'b0;
      endcase
      lit = disp_en[idx] && !blanked && (cnt != '0) && (40'(cnt) < on_len);
   end

   // Registered drivers; count 0 of every slot stays dark as dead-time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= '1;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= lit ? ~(4'b0001 << idx) : 4'b1111;
         seg        <= lit ? pattern : SEG_BLANK;
         dp         <= ~(lit && disp_dp[idx]);
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV = 8.
module tb_seven_seg_scanner;

   localparam int R = 8;
   localparam int FRAME = 4 * R;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_in, digit_en;
   logic        load, blank_lz;
   logic [2:0]  bright;
   logic [3:0]  an;
   logic [0:6]  seg;
   logic        dp, frame_tick;

   int n_pass = 0;
   int n_total = 0;

   // reference model state
   int          cyc;
   logic [15:0] m_pend_val, m_disp_val;
   logic [3:0]  m_pend_dp, m_disp_dp, m_pend_en, m_disp_en;
   logic [3:0]  e_an;
   logic [6:0]  e_seg, seg_v;
   logic        e_dp, e_ft;

   logic [6:0] hex_tbl [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seven_seg_scanner #(.REFRESH_DIV(R)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .blank_lz   (blank_lz),
      .bright     (bright),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      cyc = 0;
      m_pend_val = '0; m_disp_val = '0;
      m_pend_dp  = '0; m_disp_dp  = '0;
      m_pend_en  = '1; m_disp_en  = '1;
   endtask

   // Predict outputs for cycle 'cyc' from the scan rules, run that cycle,
   // then apply load / frame-boundary effects to the model.
   task automatic step(input bit ld);
      int slot, dig, on_len;
      bit blanked, on;
      load    = ld;
      slot    = cyc % R;
      dig     = (cyc / R) % 4;
      on_len  = ((int'(bright) + 1) * R) >> 3;
      blanked = blank_lz && dig > 0 && ((m_disp_val >> (4 * dig)) == 16'd0);
      on      = m_disp_en[dig] && !blanked && slot >= 1 && slot < on_len;
      e_an    = on ? ~(4'b0001 << dig) : 4'hF;
      e_seg   = on ? hex_tbl[4'(m_disp_val >> (4 * dig))] : 7'h7F;
      e_dp    = !(on && m_disp_dp[dig]);
      e_ft    = (slot == R - 1) && (dig == 3);
      @(posedge clk);
      #1;
      if (ld) begin
         m_pend_val = value; m_pend_dp = dp_in; m_pend_en = digit_en;
      end
      if (e_ft) begin
         m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_disp_en = m_pend_en;
      end
      cyc++;
      load = 1'b0;
   endtask

   task automatic align_frame();
      while (cyc % FRAME != 0) step(1'b0);
   endtask

   task automatic test_reset();
      logic [3:0] first;
      int first_at;
      n_total++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
         $display("FAIL reset_hold got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
      else n_pass++;
      rst_n = 1'b1;
      model_reset();
      value = 16'hABCD;
      for (int i = 0; i < 6; i++) begin
         step(i == 2);
         n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
         if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
            $display("FAIL reset_pre cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", cyc-1, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         else n_pass++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
         $display("FAIL reset_async got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", an, seg, dp, frame_tick);
      else n_pass++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      first = 4'hF; first_at = -1;
      for (int i = 0; i < 16; i++) begin
         step(1'b0);
         n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
         if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
            $display("FAIL reset_post cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", cyc-1, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         else n_pass++;
         if (first_at < 0 && an !== 4'hF) begin first = an; first_at = i; end
      end
      n_total++;
      if (first !== 4'b1110 || first_at != 1)
         $display("FAIL reset_first_lit got an=%b at cycle %0d want 1110 at cycle 1", first, first_at);
      else n_pass++;
   endtask

   task automatic test_scan();
      logic [3:0] tbl_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] tbl_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
      int tgt, c, last_tick;
      bright = 3'd7; blank_lz = 1'b0; digit_en = 4'hF; dp_in = 4'h0;
      align_frame();
      value = 16'h12AF;
      step(1'b1);
      tgt = (cyc - 1) / FRAME + 1;
      last_tick = -1;
      while (cyc < (tgt + 2) * FRAME) begin
         step(1'b0);
         c = cyc - 1;
         n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
         if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
            $display("FAIL scan cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", c, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         else n_pass++;
         if (c / FRAME == tgt && c % R == 1) begin
            n_total++;
            if (an !== tbl_an[(c / R) % 4] || seg !== tbl_seg[(c / R) % 4])
               $display("FAIL scan_digit d=%0d got an=%b seg=%b want an=%b seg=%b", (c / R) % 4, an, seg, tbl_an[(c / R) % 4], tbl_seg[(c / R) % 4]);
            else n_pass++;
         end
         if (frame_tick === 1'b1) begin
            if (last_tick >= 0) begin
               n_total++;
               if (c - last_tick != FRAME)
                  $display("FAIL frame_tick_period got %0d want %0d", c - last_tick, FRAME);
               else n_pass++;
            end
            last_tick = c;
         end
      end
   endtask

   task automatic test_blanking();
      logic [15:0] vals [2] = '{16'h0050, 16'h0000};
      int lowc [4];
      int tgt, c, d;
      bright = 3'd7; blank_lz = 1'b1; digit_en = 4'hF; dp_in = 4'h0;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) lowc[j] = 0;
         value = vals[k];
         step(1'b1);
         tgt = (cyc - 1) / FRAME + 1;
         while (cyc < (tgt + 1) * FRAME) begin
            step(1'b0);
            c = cyc - 1;
            n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
            if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
               $display("FAIL blank cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", c, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
            else n_pass++;
            if (c / FRAME == tgt) begin
               for (int j = 0; j < 4; j++) if (an[j] === 1'b0) lowc[j]++;
               d = (c / R) % 4;
               if (c % R == 1 && d == 1 && k == 0) begin
                  n_total++;
                  if (an !== 4'b1101 || seg !== 7'b0100100)
                     $display("FAIL blank_digit1 got an=%b seg=%b want an=1101 seg=0100100", an, seg);
                  else n_pass++;
               end
               if (c % R == 1 && d == 0) begin
                  n_total++;
                  if (an !== 4'b1110 || seg !== 7'b0000001)
                     $display("FAIL blank_digit0 got an=%b seg=%b want an=1110 seg=0000001", an, seg);
                  else n_pass++;
               end
            end
         end
         n_total++;
         if (lowc[3] != 0 || lowc[2] != 0 || lowc[1] != (k == 0 ? 7 : 0) || lowc[0] != 7)
            $display("FAIL blank_counts val=%h got %0d %0d %0d %0d want 0 0 %0d 7", vals[k], lowc[3], lowc[2], lowc[1], lowc[0], (k == 0 ? 7 : 0));
         else n_pass++;
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_brightness();
      logic [2:0] lv [2] = '{3'd3, 3'd0};
      int lowc [4];
      int tgt, c;
      blank_lz = 1'b0; digit_en = 4'hF; dp_in = 4'h0;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) lowc[j] = 0;
         bright = lv[k];
         value = 16'h8888;
         step(1'b1);
         tgt = (cyc - 1) / FRAME + 1;
         while (cyc < (tgt + 1) * FRAME) begin
            step(1'b0);
            c = cyc - 1;
            n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
            if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
               $display("FAIL bright cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", c, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
            else n_pass++;
            if (c / FRAME == tgt)
               for (int j = 0; j < 4; j++) if (an[j] === 1'b0) lowc[j]++;
         end
         for (int j = 0; j < 4; j++) begin
            n_total++;
            if (lowc[j] != (k == 0 ? 3 : 0))
               $display("FAIL bright_on_time level=%0d digit=%0d got %0d want %0d", lv[k], j, lowc[j], (k == 0 ? 3 : 0));
            else n_pass++;
         end
      end
      bright = 3'd7;
   endtask

   task automatic test_tearing();
      int tgt, c, bad, litc;
      bright = 3'd7; blank_lz = 1'b0; digit_en = 4'hF; dp_in = 4'h0;
      align_frame();
      value = 16'h1111;
      step(1'b1);
      tgt = (cyc - 1) / FRAME + 1;
      for (int i = 0; i < 5; i++) step(1'b0);
      value = 16'h2222;
      step(1'b1);
      bad = 0; litc = 0;
      while (cyc < (tgt + 1) * FRAME) begin
         step(1'b0);
         c = cyc - 1;
         n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
         if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
            $display("FAIL tearing cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", c, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         else n_pass++;
         if (c / FRAME == tgt && an !== 4'hF) begin
            litc++;
            if (seg !== 7'b0010010) bad++;
         end
      end
      n_total++;
      if (bad != 0 || litc != 28)
         $display("FAIL tearing_frame got bad=%0d lit=%0d want bad=0 lit=28", bad, litc);
      else n_pass++;
   endtask

   task automatic test_enable_dp();
      int tgt, c, an_bad, dp_low, dp_bad;
      bright = 3'd7; blank_lz = 1'b0;
      digit_en = 4'b0101; dp_in = 4'b0001; value = 16'h1234;
      step(1'b1);
      tgt = (cyc - 1) / FRAME + 1;
      an_bad = 0; dp_low = 0; dp_bad = 0;
      while (cyc < (tgt + 1) * FRAME) begin
         step(1'b0);
         c = cyc - 1;
         n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
         if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
            $display("FAIL enable_dp cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", c, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         else n_pass++;
         if (c / FRAME == tgt) begin
            if (an[3] === 1'b0 || an[1] === 1'b0) an_bad++;
            if (dp === 1'b0) begin
               dp_low++;
               if (an !== 4'b1110) dp_bad++;
            end
         end
      end
      n_total++;
      if (an_bad != 0 || dp_low != 7 || dp_bad != 0)
         $display("FAIL enable_dp_frame got an_bad=%0d dp_low=%0d dp_bad=%0d want 0 7 0", an_bad, dp_low, dp_bad);
      else n_pass++;
      digit_en = 4'hF; dp_in = 4'h0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         value    = 16'($urandom);
         dp_in    = 4'($urandom);
         digit_en = 4'($urandom);
         blank_lz = 1'($urandom);
         if ($urandom_range(0, 3) == 0) bright = 3'($urandom);
         value    = ($urandom_range(0, 1) == 0) ? (value & 16'h00FF) : value;
         step($urandom_range(0, 5) == 0);
         n_total++; seg_v = (e_an == 4'hF) ? 7'h7F : seg;
         if ({an, seg_v, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft})
            $display("FAIL random cyc=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b", cyc-1, an, seg_v, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
         else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0; value = '0; dp_in = '0; digit_en = 4'hF;
      load = 1'b0; blank_lz = 1'b0; bright = 3'd7;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_scan();
      test_blanking();
      test_brightness();
      test_tearing();
      test_enable_dp();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
